// File: rtl/serial_word_comparator_fsm.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_comparator_fsm
// Function : Bit-serial LT/EQ/GT comparator over N_CH channels with shared
//            framing, selectable bit order and signed/unsigned compare.
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_comparator_fsm #(
  parameter int N_CH     = 4,
  parameter int MAX_BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N_CH-1:0] a,
  input  logic [N_CH-1:0] b,
  input  logic            last,
  input  logic            msb_first,
  input  logic            is_signed,
  input  logic            abort,
  output logic            busy,
  output logic            res_valid,
  output logic [N_CH-1:0] res_lt,
  output logic [N_CH-1:0] res_eq,
  output logic [N_CH-1:0] res_gt,
  output logic            res_err
);

  localparam int              c_cnt_w    = $clog2(MAX_BITS + 1);
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(MAX_BITS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_msb;
  logic                r_sgn;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [N_CH-1:0]     r_lt;
  logic [N_CH-1:0]     r_gt;

  logic                w_first;
  logic                w_msb;
  logic                w_sgn;
  logic [c_cnt_w-1:0]  w_cnt;
  logic                w_force;
  logic                w_final;
  logic                w_inv;
  logic [N_CH-1:0]     w_cur_lt;
  logic [N_CH-1:0]     w_cur_gt;
  logic [N_CH-1:0]     w_gtb;
  logic [N_CH-1:0]     w_ltb;
  logic [N_CH-1:0]     w_nxt_lt;
  logic [N_CH-1:0]     w_nxt_gt;

  // The first bit of a word sees fresh mode bits, a zero count and EQ state,
  // so a single-bit word resolves entirely from the current inputs.
  assign w_first  = (r_state == IDLE);
  assign w_msb    = w_first ? msb_first : r_msb;
  assign w_sgn    = w_first ? is_signed : r_sgn;
  assign w_cnt    = w_first ? '0 : r_cnt;
  assign w_force  = ~last & (w_cnt == c_last_idx);
  assign w_final  = last | w_force;
  assign w_cur_lt = w_first ? '0 : r_lt;
  assign w_cur_gt = w_first ? '0 : r_gt;

  // The sign bit is first in MSB-first order and last in LSB-first order.
  assign w_inv    = w_sgn & (w_msb ? w_first : w_final);
  assign w_gtb    = w_inv ? (~a & b) : (a & ~b);
  assign w_ltb    = w_inv ? (a & ~b) : (~a & b);

  // MSB-first: first difference sticks. LSB-first: latest difference wins.
  assign w_nxt_gt = w_msb ? (w_cur_gt | (~w_cur_lt & w_gtb))
                          : (w_gtb | (w_cur_gt & ~w_ltb));
  assign w_nxt_lt = w_msb ? (w_cur_lt | (~w_cur_gt & w_ltb))
                          : (w_ltb | (w_cur_lt & ~w_gtb));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_msb     <= 1'b0;
      r_sgn     <= 1'b0;
      r_cnt     <= '0;
      r_lt      <= '0;
      r_gt      <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_lt    <= '0;
      res_eq    <= '0;
      res_gt    <= '0;
      res_err   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_lt    <= '0;
        r_gt    <= '0;
        busy    <= 1'b0;
      end else if (in_valid) begin
        if (w_first) begin
          r_msb <= msb_first;
          r_sgn <= is_signed;
        end
        if (w_final) begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_lt      <= '0;
          r_gt      <= '0;
          busy      <= 1'b0;
          res_valid <= 1'b1;
          res_lt    <= w_nxt_lt;
          res_gt    <= w_nxt_gt;
          res_eq    <= ~(w_nxt_lt | w_nxt_gt);
          res_err   <= w_force;
        end else begin
          r_state <= RUN;
          r_cnt   <= w_cnt + c_cnt_w'(1);
          r_lt    <= w_nxt_lt;
          r_gt    <= w_nxt_gt;
          busy    <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_word_comparator_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_comparator_fsm
// Function : Directed and randomized bench with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_word_comparator_fsm;

  localparam int N_CH     = 2;
  localparam int MAX_BITS = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [N_CH-1:0] a;
  logic [N_CH-1:0] b;
  logic            last;
  logic            msb_first;
  logic            is_signed;
  logic            abort;
  logic            busy;
  logic            res_valid;
  logic [N_CH-1:0] res_lt;
  logic [N_CH-1:0] res_eq;
  logic [N_CH-1:0] res_gt;
  logic            res_err;

  int checks = 0;
  int errors = 0;

  // Last expected result, used to check that outputs hold.
  logic [N_CH-1:0] e_lt, e_eq, e_gt;
  logic            e_err;

  serial_word_comparator_fsm #(.N_CH(N_CH), .MAX_BITS(MAX_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .last      (last),
    .msb_first (msb_first),
    .is_signed (is_signed),
    .abort     (abort),
    .busy      (busy),
    .res_valid (res_valid),
    .res_lt    (res_lt),
    .res_eq    (res_eq),
    .res_gt    (res_gt),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare each channel's operands as plain integers of the word length.
  task automatic model(input int len, input logic [15:0] av, input logic [15:0] bv,
                       input bit sgn, output logic [N_CH-1:0] lt,
                       output logic [N_CH-1:0] eq, output logic [N_CH-1:0] gt);
    for (int c = 0; c < N_CH; c++) begin
      int va;
      int vb;
      va = int'(av[c*8 +: 8]) & ((1 << len) - 1);
      vb = int'(bv[c*8 +: 8]) & ((1 << len) - 1);
      if (sgn && va >= (1 << (len - 1))) va -= (1 << len);
      if (sgn && vb >= (1 << (len - 1))) vb -= (1 << len);
      lt[c] = (va < vb);
      eq[c] = (va == vb);
      gt[c] = (va > vb);
    end
  endtask

  // Streams one word; returns right after the edge that accepts its final bit.
  task automatic send_word(input int len, input logic [15:0] av, input logic [15:0] bv,
                           input bit msb, input bit sgn, input bit frc, input int gaps);
    for (int i = 0; i < len; i++) begin
      int k;
      k = msb ? (len - 1 - i) : i;
      for (int c = 0; c < N_CH; c++) begin
        a[c] = av[c*8 + k];
        b[c] = bv[c*8 + k];
      end
      in_valid = 1'b1;
      last     = (i == len - 1) && !frc;
      if (i == 0) begin
        msb_first = msb;
        is_signed = sgn;
      end else begin
        msb_first = 1'($urandom);
        is_signed = 1'($urandom);
      end
      @(posedge clk); #1;
      if (i < len - 1) begin
        chk("busy_mid", {7'd0, busy}, 8'd1);
        chk("no_res_mid", {7'd0, res_valid}, 8'd0);
        repeat ($urandom_range(0, gaps)) begin
          in_valid = 1'b0;
          a        = N_CH'($urandom);
          last     = 1'($urandom);
          @(posedge clk); #1;
          chk("busy_gap", {7'd0, busy}, 8'd1);
        end
      end
    end
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [N_CH-1:0] lt,
                         input logic [N_CH-1:0] eq, input logic [N_CH-1:0] gt,
                         input logic err);
    chk({tag, "_valid"}, {7'd0, res_valid}, 8'd1);
    chk({tag, "_lt"}, 8'(res_lt), 8'(lt));
    chk({tag, "_eq"}, 8'(res_eq), 8'(eq));
    chk({tag, "_gt"}, 8'(res_gt), 8'(gt));
    chk({tag, "_err"}, {7'd0, res_err}, {7'd0, err});
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    e_lt = lt; e_eq = eq; e_gt = gt; e_err = err;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_valid"}, {7'd0, res_valid}, 8'd0);
    chk({tag, "_lt"}, 8'(res_lt), 8'd0);
    chk({tag, "_eq"}, 8'(res_eq), 8'd0);
    chk({tag, "_gt"}, 8'(res_gt), 8'd0);
    chk({tag, "_err"}, {7'd0, res_err}, 8'd0);
  endtask

  initial begin
    logic [N_CH-1:0] m_lt, m_eq, m_gt;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; last = 1'b0;
    msb_first = 1'b0; is_signed = 1'b0; abort = 1'b0;
    #1;
    chk_cleared("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cleared("post_reset");

    // ch0 0110 vs 0101 -> GT, ch1 1010 vs 1010 -> EQ
    send_word(4, {8'h0A, 8'h06}, {8'h0A, 8'h05}, 1'b1, 1'b0, 1'b0, 0);
    chk_res("msb4", 2'b00, 2'b10, 2'b01, 1'b0);
    @(posedge clk); #1;
    chk("pulse_once", {7'd0, res_valid}, 8'd0);
    chk("hold_gt", 8'(res_gt), 8'(e_gt));

    // 3 vs 4 LSB-first, without and with gaps
    send_word(4, {8'h03, 8'h03}, {8'h04, 8'h04}, 1'b0, 1'b0, 1'b0, 0);
    chk_res("lsb", 2'b11, 2'b00, 2'b00, 1'b0);
    send_word(4, {8'h03, 8'h03}, {8'h04, 8'h04}, 1'b0, 1'b0, 1'b0, 3);
    chk_res("lsb_gap", 2'b11, 2'b00, 2'b00, 1'b0);

    // 1111 vs 0001 in three modes
    send_word(4, {8'h0F, 8'h0F}, {8'h01, 8'h01}, 1'b1, 1'b1, 1'b0, 0);
    chk_res("s_msb", 2'b11, 2'b00, 2'b00, 1'b0);
    send_word(4, {8'h0F, 8'h0F}, {8'h01, 8'h01}, 1'b1, 1'b0, 1'b0, 0);
    chk_res("u_msb", 2'b00, 2'b00, 2'b11, 1'b0);
    send_word(4, {8'h0F, 8'h0F}, {8'h01, 8'h01}, 1'b0, 1'b1, 1'b0, 0);
    chk_res("s_lsb", 2'b11, 2'b00, 2'b00, 1'b0);

    // Forced termination at MAX_BITS without last
    send_word(8, {8'h80, 8'h80}, {8'h7F, 8'h7F}, 1'b1, 1'b0, 1'b1, 0);
    chk_res("force", 2'b00, 2'b00, 2'b11, 1'b1);
    send_word(1, {8'h00, 8'h01}, {8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 0);
    chk_res("after_force", 2'b00, 2'b10, 2'b01, 1'b0);

    // Abort on the 2nd bit, with last and in_valid also high
    a = 2'b01; b = 2'b10; in_valid = 1'b1; last = 1'b0; msb_first = 1'b1; is_signed = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy1", {7'd0, busy}, 8'd1);
    abort = 1'b1; last = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0; last = 1'b0;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_nores", {7'd0, res_valid}, 8'd0);
    chk("abort_hold_eq", 8'(res_eq), 8'(e_eq));
    chk("abort_hold_gt", 8'(res_gt), 8'(e_gt));
    @(posedge clk); #1;
    chk("abort_nores2", {7'd0, res_valid}, 8'd0);
    send_word(3, {8'h05, 8'h02}, {8'h05, 8'h06}, 1'b1, 1'b0, 1'b0, 0);
    chk_res("post_abort", 2'b01, 2'b10, 2'b00, 1'b0);
    send_word(1, {8'h01, 8'h01}, {8'h00, 8'h00}, 1'b1, 1'b1, 1'b0, 0);
    chk_res("one_bit_signed", 2'b11, 2'b00, 2'b00, 1'b0);

    // Randomized words against the arithmetic model
    for (int n = 0; n < 60; n++) begin
      int len;
      logic [15:0] av, bv;
      bit msb, sgn, frc;
      len = $urandom_range(1, MAX_BITS);
      av  = 16'($urandom);
      bv  = ($urandom_range(0, 3) == 0) ? av : 16'($urandom);
      msb = 1'($urandom);
      sgn = 1'($urandom);
      frc = (len == MAX_BITS) && ($urandom_range(0, 2) == 0);
      model(len, av, bv, sgn, m_lt, m_eq, m_gt);
      send_word(len, av, bv, msb, sgn, frc, $urandom_range(0, 2));
      chk_res("rand", m_lt, m_eq, m_gt, frc);
    end

    // Asynchronous reset mid-word, between edges
    a = 2'b11; b = 2'b00; in_valid = 1'b1; last = 1'b0; msb_first = 1'b1; is_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_busy_before", {7'd0, busy}, 8'd1);
    #1 rst_n = 1'b0;
    #1 chk_cleared("async_rst");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(2, {8'h02, 8'h02}, {8'h02, 8'h02}, 1'b1, 1'b0, 1'b0, 0);
    chk_res("after_rst", 2'b00, 2'b11, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_word_comparator_fsm.md
SERIAL_WORD_COMPARATOR_FSM -- requirements
Module: serial_word_comparator_fsm

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent comparison channels sharing framing and mode.
REQ-002 SHALL have parameter MAX_BITS, default 32: maximum bits per word, MAX_BITS >= 1.
REQ-003 SHALL have port clk  input  1: single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1: the bits on a/b are accepted this cycle; the block is always ready.
REQ-006 SHALL have port a  input  N_CH: current bit of operand A, one bit per channel.
REQ-007 SHALL have port b  input  N_CH: current bit of operand B, one bit per channel.
REQ-008 SHALL have port last  input  1: the accepted bit is the final bit of the word.
REQ-009 SHALL have port msb_first  input  1: bit order, 1 = MSB first, 0 = LSB first; sampled on the first bit only.
REQ-010 SHALL have port is_signed  input  1: two's-complement compare when 1; sampled on the first bit only.
REQ-011 SHALL have port abort  input  1: synchronous discard of the word in progress.
REQ-012 SHALL have port busy  output  1: high while in RUN.
REQ-013 SHALL have port res_valid  output  1: one-cycle pulse marking a new result.
REQ-014 SHALL have ports res_lt, res_eq, res_gt  output  N_CH each: per-channel registered result, one-hot per channel when res_valid.
REQ-015 SHALL have port res_err  output  1: the word was force-terminated at MAX_BITS without last.

Function
REQ-016 SHALL use a control FSM with states IDLE (awaiting the first bit) and RUN (mid-word).
REQ-017 SHALL give each channel a compare state EQ, LT or GT, set to EQ at the first bit of every word.
REQ-018 SHALL latch msb_first and is_signed when a bit is accepted in IDLE, and ignore both while in RUN.
REQ-019 SHALL use the following MSB-first update: in EQ, a&~b -> GT and ~a&b -> LT; LT and GT are sticky for the rest of the word.
REQ-020 SHALL, in MSB-first signed mode, invert the sense of the first (sign) bit only: a=1,b=0 -> LT and a=0,b=1 -> GT.
REQ-021 SHALL use the following LSB-first update: any differing bit overrides the state (a&~b -> GT, ~a&b -> LT), and equal bits keep it.
REQ-022 SHALL, in LSB-first signed mode, invert the sense of the final (sign) bit only.
REQ-023 SHALL make all results combine the current bit with the compare state, so that a single-bit word (first and last together) is correct in all four modes.
REQ-024 SHALL have a bit counter of width $clog2(MAX_BITS+1) that clears at the first bit and increments per accepted bit.
REQ-025 SHALL treat the accepted bit at count MAX_BITS-1 with last=0 as final (sign rules included) and set res_err=1.
REQ-026 SHALL register res_valid, res_lt, res_eq, res_gt and res_err on the edge that accepts the final bit, giving 1-cycle latency from the final bit to res_valid.
REQ-027 SHALL hold the result outputs until the next result; res_valid SHALL be high for exactly one cycle.
REQ-028 SHALL pass through these FSM transitions:
  - IDLE -> RUN on an accepted non-final bit.
  - Accepted final bit: IDLE -> IDLE or RUN -> IDLE.
REQ-029 SHALL leave state unchanged on cycles with in_valid=0 in RUN (gaps allowed).
REQ-030 SHALL accept a first bit on the cycle immediately after a final bit, with no bubble; the previous result still pulses.
REQ-031 SHALL, when abort=1, go to IDLE, discard the word, produce no res_valid and leave the result outputs unchanged.
REQ-032 SHALL give abort priority over in_valid in the same cycle; the bit is discarded.

Reset
REQ-033 SHALL, on rst_n low, immediately (without waiting for clk) set the following:
  - FSM = IDLE, all channels EQ, counter = 0.
  - busy = 0, res_valid = 0, res_err = 0.
  - res_lt = 0, res_eq = 0, res_gt = 0.
REQ-034 SHALL discard a word in progress on reset mid-word; the first accepted bit after rst_n rises starts a new word.

Verification
REQ-035 SHALL pass this scenario: N_CH=2, unsigned MSB-first 4-bit, ch0 A=0110 B=0101, ch1 A=B=1010 -> one cycle after the 4th bit, res_valid=1, res_gt[0]=1, res_eq[1]=1.
REQ-036 SHALL pass this scenario: unsigned LSB-first, A=3 (bits 1,1,0,0) vs B=4 (0,0,1,0) -> res_lt=1; with gaps of in_valid=0 inserted between bits the result is identical.
REQ-037 SHALL pass this scenario: 4-bit A=1111 B=0001 -> signed MSB-first gives res_lt, unsigned MSB-first gives res_gt, and signed LSB-first gives res_lt.
REQ-038 SHALL pass this scenario: MAX_BITS=8, 8 bits with last=0, A=0x80 B=0x7F unsigned MSB-first -> res_valid after the 8th bit, res_gt=1, res_err=1, busy=0; the next bit starts a new word.
REQ-039 SHALL pass this scenario: abort asserted with in_valid on the 2nd bit -> no res_valid, previous results held; the next 1-bit word A=1 B=0 signed -> res_lt, back-to-back after the prior last.
REQ-040 SHALL pass this scenario: rst_n pulsed low mid-word between clock edges -> outputs cleared before the next edge; the following 2-bit word A=10 B=10 -> res_eq=1.
